onewire_temp_responder: RTL
===========================

# onewire_temp_responder

1-Wire slave that emulates a DS18B20 on the single-wire bus, for loopback testing of the team's 1-Wire temperature master and for boards without a populated sensor. It detects master reset pulses and answers with a presence pulse. It decodes Skip ROM plus the Convert T and Read Scratchpad function commands, and shifts out a temperature word supplied by fabric logic. The block sits at the top level, sharing the `dq` pin net with the master, or replacing it.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock in Hz; `CYC_US = CLK_FREQ/1_000_000`.
- `RST_MIN_US`, 480: minimum low time classified as a bus reset.
- `PRES_DLY_US`, 30: delay from reset-pulse release to start of presence pulse.
- `PRES_LEN_US`, 120: presence pulse length.
- `SAMPLE_US`, 30: write-slot sample point after the falling edge.
- `TX0_US`, 30: hold-low time when transmitting a 0.

Ports:
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: synchronous, active-high reset.
- `dq` inout 1: open-drain bus. Only `0` or `z` is ever driven.
- `temp_in` in 16: raw DS18B20-format temperature (two's complement, 1/16 °C LSB).
- `presence` out 1: high while the presence pulse is driven.
- `cmd_valid` out 1: one-cycle pulse per received command byte.
- `cmd_byte` out 8: last received byte, valid with `cmd_valid`.
- `conv_start` out 1: one-cycle pulse on Convert T (0x44).
- `temp_latched` out 16: scratchpad temperature word.

## Operation
- `dq` passes through a 2-flop synchronizer.
- Edge detection is gated off while the block itself drives low (`dq_oe=1`).
- A 16-bit cycle counter clears on every qualified falling edge and saturates at 0xFFFF.
- Reset detect:
  - Applies in any state.
  - A qualified rising edge with low time ≥ `RST_MIN_US*CYC_US` is a reset.
  - A reset aborts the current transaction, clears the bit/byte counters, and enters `PRES_WAIT`.
- FSM states:
  - `IDLE`: wait for a reset.
  - `PRES_WAIT`: after `PRES_DLY_US`, go to `PRES_DRV`.
  - `PRES_DRV`: drive low and hold `presence=1` for `PRES_LEN_US`, then go to `ROM_CMD`.
  - `ROM_CMD`: receive 8 bits, LSB first. Each bit is sampled `SAMPLE_US` after a falling edge; 1 if the bus is high. On 0xCC go to `FUNC_CMD`; any other value goes to `IDLE`.
  - `FUNC_CMD`: receive 8 bits.
    - 0x44: `temp_latched<=temp_in`, pulse `conv_start`, then `IDLE`.
    - 0xBE: load the shift register from the scratchpad, then `TX_DATA`.
    - Any other value: `IDLE`.
  - `TX_DATA`:
    - On each falling edge, bit 0 drives low for `TX0_US` from the edge; bit 1 leaves the bus released.
    - Shift LSB first, byte 0 first.
    - After the last bit go to `IDLE`. Extra read slots read as 1.
- `cmd_valid`/`cmd_byte` pulse for both the ROM byte and the function byte, on the cycle the 8th bit is sampled.
- Falling edges seen in `PRES_WAIT`/`PRES_DRV` are ignored.
- Reset values: `dq` released, `presence=0`, `cmd_valid=0`, `cmd_byte=0`, `conv_start=0`, `temp_latched=16'h0550` (+85 °C power-on value), state `IDLE`.

## Timing
- Synchronizer latency: 2 clk. All thresholds are measured in the synchronized domain, ±1 clk.
- Presence: the bus goes low `PRES_DLY_US` (+2 clk) after the master releases, and stays low for `PRES_LEN_US`. With the default parameters, a master reset of 500 µs sampled at 570 µs sees low.
- TX 0: `dq_oe` rises 2–3 clk after the master's falling edge, so the bus stays continuously low. `dq_oe` falls at `TX0_US`.
- `conv_start` and the `temp_latched` update occur on the same clk.
- Low time ≥ `RST_MIN_US` that is still ongoing has no effect until release.

## Configuration
- `ONEWIRE_SCRATCHPAD_CRC_EN` defined:
  - 0xBE sends 9 bytes, 72 bits: `temp_latched[7:0]`, `temp_latched[15:8]`, 0x4B, 0x46, 0x7F, 0xFF, 0x0C, 0x10, then CRC8.
  - CRC8 is Dallas/Maxim X^8+X^5+X^4+1, computed over bytes 0–7.
- Not defined: 0xBE sends only the 2 temperature bytes (16 bits). No CRC logic is synthesized.

## Test plan
- Hold `dq` low 500 µs, then release → bus low from ~530 µs to ~650 µs; `presence=1` for 120 µs.
- Reset, then write 0xCC, 0x44 with `temp_in=16'h0191` → `cmd_valid` ×2 (0xCC, 0x44); `conv_start` pulse; `temp_latched=16'h0191`.
- Reset, write 0xCC, 0xBE, then 16 read slots (2 µs low, sample at 10 µs) → read bits 1,0,0,0,1,0,0,1,1,0,0,0,0,0,0,0 (0x0191). Repeat with 0xFF5E (−10.125 °C).
- 200 µs low pulse → no presence; state unchanged. ROM byte 0x33 → `cmd_valid` with 0x33; subsequent 0xBE ignored; bus never driven.
- Reset asserted after the 5th TX bit → transmission aborted; new presence pulse; a fresh 0xCC/0xBE restarts from bit 0.
- With `ONEWIRE_SCRATCHPAD_CRC_EN`, read 72 bits after latching 0x0191 → bytes 91 01 4B 46 7F FF 0C 10 followed by a CRC matching the bench model.

Source files
------------

// File: rtl/onewire_temp_responder.sv
// onewire_temp_responder: DS18B20-style 1-Wire slave with presence, Skip ROM, Convert T and Read Scratchpad.
// Define ONEWIRE_SCRATCHPAD_CRC_EN to send the full 9-byte scratchpad with CRC8 instead of the 2 temperature bytes.
module onewire_temp_responder #(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int RST_MIN_US  = 480,
    parameter int PRES_DLY_US = 30,
    parameter int PRES_LEN_US = 120,
    parameter int SAMPLE_US   = 30,
    parameter int TX0_US      = 30
) (
    input  logic        clk,
    input  logic        rst,
    inout  wire         dq,
    input  logic [15:0] temp_in,
    output logic        presence,
    output logic        cmd_valid,
    output logic [7:0]  cmd_byte,
    output logic        conv_start,
    output logic [15:0] temp_latched
);
    localparam int CYC_US = CLK_FREQ / 1_000_000;
    localparam logic [15:0] RST_CYC    = 16'(RST_MIN_US * CYC_US);
    localparam logic [15:0] PDLY_CYC   = 16'(PRES_DLY_US * CYC_US);
    localparam logic [15:0] PLEN_CYC   = 16'(PRES_LEN_US * CYC_US);
    localparam logic [15:0] SAMPLE_CYC = 16'(SAMPLE_US * CYC_US);
    localparam logic [15:0] TX0_CYC    = 16'(TX0_US * CYC_US);
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_PRES_WAIT = 3'd1;
    localparam logic [2:0] S_PRES_DRV  = 3'd2;
    localparam logic [2:0] S_ROM_CMD   = 3'd3;
    localparam logic [2:0] S_FUNC_CMD  = 3'd4;
    localparam logic [2:0] S_TX_DATA   = 3'd5;
`ifdef ONEWIRE_SCRATCHPAD_CRC_EN
    localparam int NBITS = 72;
`else
    localparam int NBITS = 16;
`endif

    logic [1:0]       r_sync;
    logic             r_prev;
    logic             r_oe;
    logic [15:0]      r_cnt;
    logic [15:0]      r_tmr;
    logic [2:0]       r_state;
    logic             r_armed;
    logic [6:0]       r_bits;
    logic [6:0]       r_rx;
    logic [NBITS-1:0] r_shift;
    logic [NBITS-1:0] w_load;
    logic             w_dq;
    logic             w_fall;
    logic             w_rise;
    logic             w_bus_rst;
    logic             w_sample;
    logic [7:0]       w_byte;

    assign dq        = r_oe ? 1'b0 : 1'bz;
    assign w_dq      = r_sync[1];
    assign w_fall    = r_prev & ~w_dq & ~r_oe;
    assign w_rise    = ~r_prev & w_dq & ~r_oe;
    assign w_bus_rst = w_rise && (r_cnt >= RST_CYC);
    assign w_sample  = r_armed && (r_tmr == SAMPLE_CYC);
    assign w_byte    = {w_dq, r_rx};

`ifdef ONEWIRE_SCRATCHPAD_CRC_EN
    logic [63:0] w_pad;
    logic [7:0]  w_crc;
    assign w_pad = {48'h100C_FF7F_464B, temp_latched};
    always_comb begin
        w_crc = 8'h00;
        for (int i = 0; i < 64; i++)
            w_crc = (w_crc[0] ^ w_pad[i]) ? ({1'b0, w_crc[7:1]} ^ 8'h8C) : {1'b0, w_crc[7:1]};
    end
    assign w_load = {w_crc, w_pad};
`else
    assign w_load = temp_latched;
`endif

    // Low-time counter restarts at our presence release so that edge is never mistaken for a master reset.
    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_fall || (r_state == S_PRES_DRV && r_tmr == PLEN_CYC - 16'd1))
            r_cnt <= '0;
        else if (r_cnt != 16'hFFFF)
            r_cnt <= r_cnt + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync       <= 2'b11;
            r_prev       <= 1'b1;
            r_oe         <= 1'b0;
            r_tmr        <= '0;
            r_state      <= S_IDLE;
            r_armed      <= 1'b0;
            r_bits       <= '0;
            r_rx         <= '0;
            r_shift      <= '0;
            presence     <= 1'b0;
            cmd_valid    <= 1'b0;
            cmd_byte     <= '0;
            conv_start   <= 1'b0;
            temp_latched <= 16'h0550;
        end else begin
            r_sync     <= {r_sync[0], dq};
            r_prev     <= w_dq;
            cmd_valid  <= 1'b0;
            conv_start <= 1'b0;
            if (r_tmr != 16'hFFFF) r_tmr <= r_tmr + 16'd1;
            if (w_bus_rst) begin
                r_state  <= S_PRES_WAIT;
                r_tmr    <= '0;
                r_oe     <= 1'b0;
                r_armed  <= 1'b0;
                r_bits   <= '0;
                presence <= 1'b0;
            end else begin
                case (r_state)
                    S_PRES_WAIT: if (r_tmr == PDLY_CYC - 16'd1) begin
                        r_state  <= S_PRES_DRV;
                        r_tmr    <= '0;
                        r_oe     <= 1'b1;
                        presence <= 1'b1;
                    end
                    S_PRES_DRV: if (r_tmr == PLEN_CYC - 16'd1) begin
                        r_state  <= S_ROM_CMD;
                        r_tmr    <= '0;
                        r_oe     <= 1'b0;
                        presence <= 1'b0;
                    end
                    S_ROM_CMD, S_FUNC_CMD: begin
                        if (w_fall) begin
                            r_armed <= 1'b1;
                            r_tmr   <= '0;
                        end else if (w_sample) begin
                            r_armed <= 1'b0;
                            r_rx    <= w_byte[7:1];
                            r_bits  <= r_bits + 7'd1;
                            if (r_bits == 7'd7) begin
                                r_bits    <= '0;
                                cmd_valid <= 1'b1;
                                cmd_byte  <= w_byte;
                                if (r_state == S_ROM_CMD)
                                    r_state <= (w_byte == 8'hCC) ? S_FUNC_CMD : S_IDLE;
                                else if (w_byte == 8'h44) begin
                                    temp_latched <= temp_in;
                                    conv_start   <= 1'b1;
                                    r_state      <= S_IDLE;
                                end else if (w_byte == 8'hBE) begin
                                    r_shift <= w_load;
                                    r_tmr   <= '0;
                                    r_state <= S_TX_DATA;
                                end else
                                    r_state <= S_IDLE;
                            end
                        end
                    end
                    S_TX_DATA: begin
                        if (w_fall && r_bits != 7'(NBITS)) begin
                            r_oe    <= ~r_shift[0];
                            r_shift <= {1'b1, r_shift[NBITS-1:1]};
                            r_bits  <= r_bits + 7'd1;
                            r_tmr   <= '0;
                        end else if (r_tmr == TX0_CYC) begin
                            r_oe <= 1'b0;
                            if (r_bits == 7'(NBITS)) begin
                                r_bits  <= '0;
                                r_state <= S_IDLE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
